// File: rtl/sonar_multicanal_pkg.sv
// Shared definitions for the multichannel sonar: FSM state encoding (mirrored
// on db_estado), BCD sizing and a constant BCD conversion helper.
package sonar_multicanal_pkg;

    localparam int BCD_DIG_W = 4;
    localparam int BCD_N_DIG = 3;
    localparam int BCD_W     = BCD_DIG_W * BCD_N_DIG;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PREP      = 4'd1,
        S_TRIGGER   = 4'd2,
        S_WAIT_ECHO = 4'd3,
        S_MEDE      = 4'd4,
        S_ARMAZENA  = 4'd5,
        S_ESPERA    = 4'd6,
        S_FIM       = 4'd7
    } estado_t;

    function automatic logic [BCD_W-1:0] to_bcd(input int valor);
        return {4'((valor / 100) % 10), 4'((valor / 10) % 10), 4'(valor % 10)};
    endfunction

endpackage

// File: rtl/sonar_multicanal_if.sv
// Sensor-side and result-side signal bundle of the multichannel sonar.
interface sonar_multicanal_if
    import sonar_multicanal_pkg::*;
#(
    parameter int N_CANAIS = 2
);
    localparam int CANAL_W = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

    logic                      medir;
    logic                      continuo;
    logic [N_CANAIS-1:0]       echo;
    logic [N_CANAIS-1:0]       trigger;
    logic [BCD_W*N_CANAIS-1:0] medida;
    logic [N_CANAIS-1:0]       valido;
    logic [N_CANAIS-1:0]       erro;
    logic [CANAL_W-1:0]        canal_atual;
    logic                      ocupado;
    logic                      pronto;
    logic [3:0]                db_estado;

    modport master (
        output medir, continuo, echo,
        input  trigger, medida, valido, erro, canal_atual, ocupado, pronto, db_estado
    );

    modport slave (
        input  medir, continuo, echo,
        output trigger, medida, valido, erro, canal_atual, ocupado, pronto, db_estado
    );

endinterface

// File: rtl/sonar_multicanal_contador_bcd.sv
// Three-digit BCD centimetre counter: synchronous clear, enable, holds at MAX_CM.
module contador_bcd_cm
    import sonar_multicanal_pkg::*;
#(
    parameter int MAX_CM = 999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             limpa,
    input  logic             incrementa,
    output logic [BCD_W-1:0] bcd
);
    localparam logic [BCD_W-1:0] BCD_MAX = to_bcd(MAX_CM);

    logic [BCD_W-1:0]     bcd_reg;
    logic [BCD_W-1:0]     bcd_next;
    logic [BCD_N_DIG-1:0] carry;

    // Saturation gates the carry into the least significant digit.
    assign carry[0] = incrementa && (bcd_reg != BCD_MAX);

    genvar gi;
    for (gi = 0; gi < BCD_N_DIG; gi++) begin : g_dig
        logic [BCD_DIG_W-1:0] dig;
        assign dig = bcd_reg[BCD_DIG_W*gi +: BCD_DIG_W];
        assign bcd_next[BCD_DIG_W*gi +: BCD_DIG_W] =
            !carry[gi]                 ? dig :
            (dig == BCD_DIG_W'(9))     ? '0  : dig + BCD_DIG_W'(1);
        if (gi < BCD_N_DIG - 1) begin : g_carry
            assign carry[gi+1] = carry[gi] && (dig == BCD_DIG_W'(9));
        end
    end

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            bcd_reg <= '0;
        end else begin
            bcd_reg <= bcd_next;
        end
    end

    assign bcd = bcd_reg;

endmodule

// File: rtl/sonar_multicanal.sv
// Round-robin HC-SR04 style sonar over N_CANAIS sensors: trigger, echo timing,
// rounded BCD centimetres and per-channel valid/timeout flags.
module sonar_multicanal
    import sonar_multicanal_pkg::*;
#(
    parameter int N_CANAIS    = 2,
    parameter int CYC_POR_CM  = 2941,
    parameter int TRIG_CYC    = 500,
    parameter int TIMEOUT_CYC = 1_900_000,
    parameter int GAP_CYC     = 50_000,
    parameter int MAX_CM      = 999
) (
    input  logic               clock,
    input  logic               reset,
    sonar_multicanal_if.slave  bus
);
    localparam int CANAL_W = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
    localparam int SUB_W   = (CYC_POR_CM > 1) ? $clog2(CYC_POR_CM) : 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int FASE_W  = $clog2(((TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC) + 1);
    localparam logic [SUB_W-1:0]   SUB_INICIO   = SUB_W'(CYC_POR_CM / 2);
    localparam logic [SUB_W-1:0]   SUB_FIM      = SUB_W'(CYC_POR_CM - 1);
    localparam logic [CANAL_W-1:0] CANAL_ULTIMO = CANAL_W'(N_CANAIS - 1);

    estado_t             estado_reg, estado_next;
    logic [CANAL_W-1:0]  canal_reg, canal_next;
    logic                falha_reg, falha_next;
    logic [FASE_W-1:0]   fase_reg;
    logic [SUB_W-1:0]    sub_reg;
    logic [TO_W-1:0]     to_reg;
    logic [N_CANAIS-1:0] sync1_reg, sync2_reg;
    logic                eco_ant_reg;
    logic [N_CANAIS-1:0] sel_vec;
    logic [BCD_W-1:0]    bcd;
    logic                limpa, conta, eco_sel, subida, descida, estouro, armazena;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            eco_ant_reg <= 1'b0;
        end else begin
            sync1_reg   <= bus.echo;
            sync2_reg   <= sync1_reg;
            eco_ant_reg <= eco_sel;
        end
    end

    // Edges come only from the serviced channel; an echo already high on
    // entering WAIT_ECHO cannot produce a rising edge until it goes low.
    assign eco_sel  = |(sync2_reg & sel_vec);
    assign subida   = eco_sel & ~eco_ant_reg;
    assign descida  = ~eco_sel & eco_ant_reg;
    assign estouro  = (to_reg == TO_W'(TIMEOUT_CYC));
    assign armazena = (estado_reg == S_ARMAZENA);

    always_comb begin
        estado_next = estado_reg;
        canal_next  = canal_reg;
        falha_next  = falha_reg;
        limpa       = 1'b0;
        conta       = 1'b0;
        unique case (estado_reg)
            S_IDLE: begin
                if (bus.medir || bus.continuo) begin
                    estado_next = S_PREP;
                    canal_next  = '0;
                end
            end
            S_PREP: begin
                limpa       = 1'b1;
                falha_next  = 1'b0;
                estado_next = S_TRIGGER;
            end
            S_TRIGGER: begin
                if (fase_reg == FASE_W'(TRIG_CYC - 1)) estado_next = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (estouro) begin
                    falha_next  = 1'b1;
                    estado_next = S_ARMAZENA;
                end else if (subida) begin
                    estado_next = S_MEDE;
                end
            end
            S_MEDE: begin
                if (estouro) begin
                    falha_next  = 1'b1;
                    estado_next = S_ARMAZENA;
                end else begin
                    conta = 1'b1;
                    if (descida) estado_next = S_ARMAZENA;
                end
            end
            S_ARMAZENA: estado_next = S_ESPERA;
            S_ESPERA: begin
                if (fase_reg == FASE_W'(GAP_CYC - 1)) begin
                    if (canal_reg == CANAL_ULTIMO) begin
                        estado_next = S_FIM;
                    end else begin
                        canal_next  = canal_reg + CANAL_W'(1);
                        estado_next = S_PREP;
                    end
                end
            end
            S_FIM: begin
                if (bus.continuo) begin
                    estado_next = S_PREP;
                    canal_next  = '0;
                end else begin
                    estado_next = S_IDLE;
                end
            end
            default: estado_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= S_IDLE;
            canal_reg  <= '0;
            falha_reg  <= 1'b0;
            fase_reg   <= '0;
            sub_reg    <= '0;
            to_reg     <= '0;
        end else begin
            estado_reg <= estado_next;
            canal_reg  <= canal_next;
            falha_reg  <= falha_next;
            fase_reg   <= (estado_next != estado_reg) ? '0 : fase_reg + FASE_W'(1);
            if (limpa) begin
                // Half-cm preload turns the truncating divide into round-half-up.
                sub_reg <= SUB_INICIO;
                to_reg  <= '0;
            end else begin
                if (conta) sub_reg <= (sub_reg == SUB_FIM) ? '0 : sub_reg + SUB_W'(1);
                if (estado_reg == S_WAIT_ECHO || estado_reg == S_MEDE) to_reg <= to_reg + TO_W'(1);
            end
        end
    end

    contador_bcd_cm #(
        .MAX_CM (MAX_CM)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .limpa      (limpa),
        .incrementa (conta && (sub_reg == SUB_FIM)),
        .bcd        (bcd)
    );

    genvar gi;
    for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
        logic [BCD_W-1:0] medida_reg;
        logic             valido_reg;
        logic             erro_reg;

        assign sel_vec[gi]     = (canal_reg == CANAL_W'(gi));
        assign bus.trigger[gi] = (estado_reg == S_TRIGGER) && sel_vec[gi];
        assign bus.medida[BCD_W*gi +: BCD_W] = medida_reg;
        assign bus.valido[gi]  = valido_reg;
        assign bus.erro[gi]    = erro_reg;

        // A timed-out attempt keeps the last good distance on display.
        always_ff @(posedge clock) begin
            if (reset) begin
                medida_reg <= '0;
                valido_reg <= 1'b0;
                erro_reg   <= 1'b0;
            end else if (armazena && sel_vec[gi]) begin
                if (!falha_reg) medida_reg <= bcd;
                valido_reg <= ~falha_reg;
                erro_reg   <= falha_reg;
            end
        end
    end

    assign bus.canal_atual = canal_reg;
    assign bus.ocupado     = (estado_reg != S_IDLE);
    assign bus.pronto      = (estado_reg == S_FIM);
    assign bus.db_estado   = estado_reg;

endmodule
